aud_recorder: RTL and testbench

Capture stage upstream of the SRAM write path in the lab3 voice recorder. Deserialises the WM8731 ADC I2S stream (left channel only, 16-bit two's complement) into one sample per LRC frame. Each sample becomes a single-cycle SRAM write request with an incrementing address. Controlled by debounced start, pause and stop pulses from the top-level controller; reports the recorded length for playback and for the HEX display.

---
 rtl/aud_recorder_if.sv | 30 +++
 rtl/aud_recorder.sv | 125 ++++++++++++
 tb/tb_aud_recorder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/aud_recorder_if.sv
// SRAM write bus and recording status driven by the capture stage.
interface aud_recorder_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] o_address;
    logic [DATA_W-1:0] o_data;
    logic              o_we;
    logic [ADDR_W-1:0] o_len;
    logic              o_busy;
    logic              o_full;

    modport master (
        output o_address,
        output o_data,
        output o_we,
        output o_len,
        output o_busy,
        output o_full
    );

    modport slave (
        input o_address,
        input o_data,
        input o_we,
        input o_len,
        input o_busy,
        input o_full
    );
endinterface

// File: rtl/aud_recorder.sv
// I2S left-channel capture: one SRAM write per LRC frame,
// with start/pause/stop control and recorded-length tracking.
module aud_recorder #(
    parameter int              ADDR_W   = 20,
    parameter int              DATA_W   = 16,
    parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lrc,
    input  logic i_data,
    input  logic i_start,
    input  logic i_pause,
    input  logic i_stop,
    aud_recorder_if.master o_wr
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SHIFT,
        S_WRITE,
        S_PAUSED
    } state_t;

    state_t            r_state;
    logic              r_lrc_d;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_pend;
    logic              w_fall;

    assign w_fall = r_lrc_d & ~i_lrc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_lrc_d        <= 1'b1;
            r_cnt          <= '0;
            r_shift        <= '0;
            r_pend         <= 1'b0;
            o_wr.o_address <= '0;
            o_wr.o_data    <= '0;
            o_wr.o_we      <= 1'b0;
            o_wr.o_len     <= '0;
            o_wr.o_busy    <= 1'b0;
            o_wr.o_full    <= 1'b0;
        end else begin
            r_lrc_d   <= i_lrc;
            o_wr.o_we <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state        <= S_WAIT;
                        o_wr.o_busy    <= 1'b1;
                        o_wr.o_address <= '0;
                        o_wr.o_len     <= '0;
                        o_wr.o_full    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (i_stop) begin
                        r_state     <= S_IDLE;
                        o_wr.o_busy <= 1'b0;
                    end else if (i_pause) begin
                        r_state <= S_PAUSED;
                    end else if (w_fall) begin
                        // E0 carries the I2S one-bit delay; no data taken
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                        r_pend  <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (i_stop) begin
                        r_state     <= S_IDLE;
                        o_wr.o_busy <= 1'b0;
                    end else begin
                        r_shift <= {r_shift[DATA_W-2:0], i_data};
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (i_pause)
                            r_pend <= 1'b1;
                        if (r_cnt == CNT_W'(DATA_W-1)) begin
                            r_state     <= S_WRITE;
                            o_wr.o_we   <= 1'b1;
                            o_wr.o_data <= {r_shift[DATA_W-2:0], i_data};
                        end
                    end
                end
                S_WRITE: begin
                    o_wr.o_len <= o_wr.o_address + ADDR_W'(1);
                    r_pend     <= 1'b0;
                    if (o_wr.o_address == MAX_ADDR) begin
                        r_state     <= S_IDLE;
                        o_wr.o_busy <= 1'b0;
                        o_wr.o_full <= 1'b1;
                    end else begin
                        o_wr.o_address <= o_wr.o_address + ADDR_W'(1);
                        if (i_stop) begin
                            r_state     <= S_IDLE;
                            o_wr.o_busy <= 1'b0;
                        end else if (i_pause || r_pend) begin
                            r_state <= S_PAUSED;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_PAUSED: begin
                    if (i_stop) begin
                        r_state     <= S_IDLE;
                        o_wr.o_busy <= 1'b0;
                    end else if (i_start) begin
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    o_wr.o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder: frame table plus reset and
// auto-stop sequences.
module tb_aud_recorder;
    logic clk;
    logic rst;
    logic lrc;
    logic sdat;
    logic start;
    logic pause;
    logic stop;

    aud_recorder_if #(.ADDR_W(20), .DATA_W(16)) wr ();
    aud_recorder_if #(.ADDR_W(20), .DATA_W(16)) mwr ();

    aud_recorder #(.ADDR_W(20), .DATA_W(16)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_lrc   (lrc),
        .i_data  (sdat),
        .i_start (start),
        .i_pause (pause),
        .i_stop  (stop),
        .o_wr    (wr)
    );

    aud_recorder #(
        .ADDR_W   (20),
        .DATA_W   (16),
        .MAX_ADDR (20'h3)
    ) dut_m (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_lrc   (lrc),
        .i_data  (sdat),
        .i_start (start),
        .i_pause (pause),
        .i_stop  (stop),
        .o_wr    (mwr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int m_wr_cnt = 0;
    logic [19:0] last_addr = '0;
    logic [15:0] last_data = '0;
    logic [19:0] m_last_addr = '0;

    typedef struct {
        int          pre;
        logic [15:0] s;
        int          pa;
        int          sp;
        int          nwr;
        logic [19:0] waddr;
        logic [19:0] lpre;
        logic [19:0] len;
        logic [19:0] addr;
        logic        busy;
    } vec_t;

    vec_t tv[18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // drive one cycle of inputs, then observe after the rising edge
    task automatic cyc(input logic l, input logic d, input logic st,
                       input logic pa, input logic sp, input logic rs);
        lrc = l;
        sdat = d;
        start = st;
        pause = pa;
        stop = sp;
        rst = rs;
        @(negedge clk);
        if (wr.o_we === 1'b1) begin
            wr_cnt++;
            last_addr = wr.o_address;
            last_data = wr.o_data;
        end
        if (mwr.o_we === 1'b1) begin
            m_wr_cnt++;
            m_last_addr = mwr.o_address;
        end
    endtask

    function automatic logic frame_bit(input logic [15:0] s, input int k);
        if (k == 0)
            return 1'b1;
        else if (k <= 16)
            return s[16-k];
        else if (k < 32)
            return 1'b1;
        else
            return k[0];
    endfunction

    task automatic frame(input logic [15:0] s, input int pa_at,
                         input int sp_at, output int we_k);
        we_k = -1;
        for (int k = 0; k < 64; k++) begin
            cyc(k >= 32, frame_bit(s, k), 1'b0, k == pa_at, k == sp_at, 1'b0);
            if (wr.o_we === 1'b1 && we_k < 0)
                we_k = k;
        end
    endtask

    initial begin
        int base;
        int wk;

        lrc = 1'b1;
        sdat = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        stop = 1'b0;
        rst = 1'b1;

        tv[0]  = '{2, 16'hA5C3, -1, -1, 1, 0, 0, 1, 1, 1'b1};
        tv[1]  = '{2, 16'h0001, -1, -1, 1, 0, 0, 1, 1, 1'b1};
        tv[2]  = '{0, 16'h8000, -1, -1, 1, 1, 0, 2, 2, 1'b1};
        tv[3]  = '{0, 16'hFFFF, -1, -1, 1, 2, 0, 3, 3, 1'b1};
        tv[4]  = '{2, 16'h1234, -1, -1, 1, 0, 0, 1, 1, 1'b1};
        tv[5]  = '{0, 16'h5678,  5, -1, 1, 1, 0, 2, 2, 1'b1};
        tv[6]  = '{0, 16'h9ABC, -1, -1, 0, 0, 0, 2, 2, 1'b1};
        tv[7]  = '{0, 16'h9ABC, -1, -1, 0, 0, 0, 2, 2, 1'b1};
        tv[8]  = '{0, 16'h9ABC, -1, -1, 0, 0, 0, 2, 2, 1'b1};
        tv[9]  = '{1, 16'hDEF0, -1, -1, 1, 2, 2, 3, 3, 1'b1};
        tv[10] = '{0, 16'h4321, -1, 10, 0, 0, 0, 3, 3, 1'b0};
        tv[11] = '{1, 16'h0F0F, -1, -1, 1, 0, 0, 1, 1, 1'b1};
        tv[12] = '{3, 16'h1111, -1, -1, 0, 0, 0, 1, 1, 1'b1};
        tv[13] = '{1, 16'h2222, -1, -1, 1, 1, 1, 2, 2, 1'b1};
        tv[14] = '{0, 16'h3333, -1, 17, 1, 2, 0, 3, 3, 1'b0};
        tv[15] = '{2, 16'h4444, 17, -1, 1, 0, 0, 1, 1, 1'b1};
        tv[16] = '{0, 16'h5555, -1, -1, 0, 0, 0, 1, 1, 1'b1};
        tv[17] = '{4, 16'h6666, -1, -1, 0, 0, 0, 1, 1, 1'b0};

        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_addr", 32'(wr.o_address), 0);
        chk("rst_data", 32'(wr.o_data), 0);
        chk("rst_we", 32'(wr.o_we), 0);
        chk("rst_len", 32'(wr.o_len), 0);
        chk("rst_busy", 32'(wr.o_busy), 0);
        chk("rst_full", 32'(wr.o_full), 0);

        // reset in the middle of a sample
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            cyc(1'b0, frame_bit(16'hFFFF, k), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_busy_pre", 32'(wr.o_busy), 1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mid_addr", 32'(wr.o_address), 0);
        chk("mid_we", 32'(wr.o_we), 0);
        chk("mid_len", 32'(wr.o_len), 0);
        chk("mid_busy", 32'(wr.o_busy), 0);
        chk("mid_data", 32'(wr.o_data), 0);
        base = wr_cnt;
        for (int k = 9; k < 49; k++)
            cyc(k >= 32, frame_bit(16'hFFFF, k), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_nowrite", 32'(wr_cnt - base), 0);

        for (int i = 0; i < 18; i++) begin
            if (tv[i].pre == 2 || tv[i].pre == 4)
                cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (tv[i].pre == 1 || tv[i].pre == 2)
                cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (tv[i].pre == 3)
                cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            if (tv[i].pre == 1 || tv[i].pre == 2)
                chk($sformatf("v%0d_len_pre", i), 32'(wr.o_len),
                    32'(tv[i].lpre));
            base = wr_cnt;
            frame(tv[i].s, tv[i].pa, tv[i].sp, wk);
            chk($sformatf("v%0d_nwr", i), 32'(wr_cnt - base), tv[i].nwr);
            if (tv[i].nwr > 0) begin
                chk($sformatf("v%0d_lat", i), 32'(wk), 16);
                chk($sformatf("v%0d_waddr", i), 32'(last_addr),
                    32'(tv[i].waddr));
                chk($sformatf("v%0d_wdata", i), 32'(last_data),
                    32'(tv[i].s));
            end
            chk($sformatf("v%0d_len", i), 32'(wr.o_len), 32'(tv[i].len));
            chk($sformatf("v%0d_addr", i), 32'(wr.o_address),
                32'(tv[i].addr));
            chk($sformatf("v%0d_busy", i), 32'(wr.o_busy),
                32'(tv[i].busy));
        end

        // auto-stop at MAX_ADDR = 3
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        base = m_wr_cnt;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 5; f++)
            frame(16'(16'h1000 + f), -1, -1, wk);
        chk("max_nwr", 32'(m_wr_cnt - base), 4);
        chk("max_last_waddr", 32'(m_last_addr), 3);
        chk("max_full", 32'(mwr.o_full), 1);
        chk("max_busy", 32'(mwr.o_busy), 0);
        chk("max_len", 32'(mwr.o_len), 4);
        chk("max_addr", 32'(mwr.o_address), 3);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("max_full_clr", 32'(mwr.o_full), 0);
        chk("max_len_clr", 32'(mwr.o_len), 0);
        chk("max_busy_restart", 32'(mwr.o_busy), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
